// File: rtl/argmax_classifier.sv
// Serial argmax over one frame of post-ReLU class scores.
// Reports winner index, winner score, runner-up score and margin.
module argmax_classifier #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = $clog2(CLASS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  score_valid,
  output logic                  score_ready,
  input  logic [DATA_WIDTH-1:0] score_data,
  input  logic                  score_last,
  output logic                  class_valid,
  input  logic                  class_ready,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic [DATA_WIDTH-1:0] runner_up_score,
  output logic [DATA_WIDTH-1:0] margin,
  output logic                  frame_error
);

  typedef enum logic {
    COLLECT,
    PRESENT
  } state_e;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(CLASS_COUNT - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] second_q, second_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] score_q, score_d;
  logic [DATA_WIDTH-1:0] runner_q, runner_d;
  logic                  ferr_q, ferr_d;

  logic                  beat;
  logic                  at_last;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] upd_best;
  logic [IDX_WIDTH-1:0]  upd_idx;
  logic [DATA_WIDTH-1:0] upd_second;

  assign beat      = score_valid && ready_q;
  assign at_last   = (cnt_q == LAST_IDX);
  assign frame_end = score_last || at_last;

  // Running top-two; strict compare keeps the lowest index on ties.
  always_comb begin
    upd_best   = best_q;
    upd_idx    = best_idx_q;
    upd_second = second_q;
    if (cnt_q == '0) begin
      upd_best   = score_data;
      upd_idx    = '0;
      upd_second = '0;
    end else if (score_data > best_q) begin
      upd_second = best_q;
      upd_best   = score_data;
      upd_idx    = cnt_q;
    end else if (score_data > second_q) begin
      upd_second = score_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    second_d   = second_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    score_d    = score_q;
    runner_d   = runner_q;
    ferr_d     = ferr_q;
    unique case (state_q)
      COLLECT: begin
        if (beat) begin
          best_d     = upd_best;
          best_idx_d = upd_idx;
          second_d   = upd_second;
          cnt_d      = cnt_q + IDX_WIDTH'(1);
          if (frame_end) begin
            idx_d    = upd_idx;
            score_d  = upd_best;
            runner_d = upd_second;
            ferr_d   = ~(score_last && at_last);
            cnt_d    = '0;
            state_d  = PRESENT;
            ready_d  = 1'b0;
            valid_d  = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (class_ready) begin
          state_d = COLLECT;
          ready_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      second_q   <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      score_q    <= '0;
      runner_q   <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      second_q   <= second_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      runner_q   <= runner_d;
      ferr_q     <= ferr_d;
    end
  end

  assign score_ready     = ready_q;
  assign class_valid     = valid_q;
  assign class_idx       = idx_q;
  assign class_score     = score_q;
  assign runner_up_score = runner_q;
  assign frame_error     = ferr_q;
  // runner_q never exceeds score_q, so this cannot wrap.
  assign margin          = score_q - runner_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: directed table, corner sequences
// and random frames against a top-two reference model.
module tb_argmax_classifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        score_valid;
  logic        score_ready;
  logic [31:0] score_data;
  logic        score_last;
  logic        class_valid;
  logic        class_ready;
  logic [3:0]  class_idx;
  logic [31:0] class_score;
  logic [31:0] runner_up_score;
  logic [31:0] margin;
  logic        frame_error;

  int n_vec = 0;
  int n_err = 0;

  argmax_classifier #(
    .CLASS_COUNT(10),
    .DATA_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .score_valid    (score_valid),
    .score_ready    (score_ready),
    .score_data     (score_data),
    .score_last     (score_last),
    .class_valid    (class_valid),
    .class_ready    (class_ready),
    .class_idx      (class_idx),
    .class_score    (class_score),
    .runner_up_score(runner_up_score),
    .margin         (margin),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              n;
    logic [9:0][31:0] s;
    int              lp;
    logic [3:0]      idx;
    logic [31:0]     sc;
    logic [31:0]     ru;
    logic [31:0]     mg;
    logic            err;
    int              gap;
    int              hold;
  } vec_t;

  function automatic logic [9:0][31:0] sv(
    input logic [31:0] a0, a1, a2, a3, a4,
    input logic [31:0] a5, a6, a7, a8, a9);
    logic [9:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
    r[5] = a5; r[6] = a6; r[7] = a7; r[8] = a8; r[9] = a9;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Argmax = first index holding the maximum; runner-up = largest
  // score among the other positions (0 if the frame has one beat).
  function automatic void model(
    input  logic [9:0][31:0] s,
    input  int               n,
    input  int               lp,
    output logic [3:0]       idx,
    output logic [31:0]      b,
    output logic [31:0]      r,
    output logic             e);
    logic [31:0] mx;
    mx = 0;
    for (int i = 0; i < n; i++) if (s[i] > mx) mx = s[i];
    idx = 0;
    for (int i = n - 1; i >= 0; i--) if (s[i] == mx) idx = 4'(i);
    b = mx;
    r = 0;
    for (int i = 0; i < n; i++)
      if (i != int'(idx) && s[i] > r) r = s[i];
    e = !(n == 10 && lp == 9);
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(score_ready), 1);
    chk({tag, "_valid"}, 32'(class_valid), 0);
    chk({tag, "_idx"}, 32'(class_idx), 0);
    chk({tag, "_score"}, class_score, 0);
    chk({tag, "_runner"}, runner_up_score, 0);
    chk({tag, "_margin"}, margin, 0);
    chk({tag, "_ferr"}, 32'(frame_error), 0);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_idx"}, 32'(class_idx), 32'(v.idx));
    chk({tag, "_score"}, class_score, v.sc);
    chk({tag, "_runner"}, runner_up_score, v.ru);
    chk({tag, "_margin"}, margin, v.mg);
    chk({tag, "_ferr"}, 32'(frame_error), 32'(v.err));
  endtask

  task automatic send_beats(input logic [9:0][31:0] s,
                            input int n, input int lp,
                            input int gap);
    int k;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        score_valid = 1'b0;
        score_data  = $urandom;
        score_last  = 1'b1;
        @(negedge clk);
      end
      k = 0;
      while (!score_ready && k < 50) begin
        k++;
        @(negedge clk);
      end
      if (!score_ready) chk("ready_timeout", 0, 1);
      score_valid = 1'b1;
      score_data  = s[i];
      score_last  = (i == lp);
      @(negedge clk);
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    class_ready = (v.hold == 0);
    send_beats(v.s, v.n, v.lp, v.gap);
    chk({tag, "_lat_valid"}, 32'(class_valid), 1);
    chk({tag, "_lat_ready"}, 32'(score_ready), 0);
    check_result(tag, v);
    for (int h = 0; h < v.hold; h++) begin
      score_valid = 1'b1;
      score_data  = $urandom;
      score_last  = 1'($urandom);
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(class_valid), 1);
      chk({tag, "_bp_ready"}, 32'(score_ready), 0);
      check_result({tag, "_bp"}, v);
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
    class_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_hs_valid"}, 32'(class_valid), 0);
    chk({tag, "_hs_ready"}, 32'(score_ready), 1);
    check_result({tag, "_hold"}, v);
    class_ready = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [9:0][31:0] nom;
    nom = sv(5, 2, 9, 0, 1, 7, 3, 8, 4, 6);

    tbl[0] = '{n:10, s:nom, lp:9, idx:2, sc:9, ru:8, mg:1,
               err:0, gap:0, hold:0};
    tbl[1] = '{n:10, s:sv(0, 4, 4, 0, 0, 0, 0, 0, 0, 0), lp:9,
               idx:1, sc:4, ru:4, mg:0, err:0, gap:0, hold:0};
    tbl[2] = '{n:10, s:sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), lp:9,
               idx:0, sc:0, ru:0, mg:0, err:0, gap:0, hold:0};
    tbl[3] = '{n:10, s:nom, lp:9, idx:2, sc:9, ru:8, mg:1,
               err:0, gap:40, hold:5};
    tbl[4] = '{n:10, s:nom, lp:9, idx:2, sc:9, ru:8, mg:1,
               err:0, gap:0, hold:0};
    tbl[5] = '{n:4, s:sv(1, 9, 2, 3, 0, 0, 0, 0, 0, 0), lp:3,
               idx:1, sc:9, ru:3, mg:6, err:1, gap:0, hold:0};
    tbl[6] = '{n:10, s:nom, lp:9, idx:2, sc:9, ru:8, mg:1,
               err:0, gap:0, hold:0};
    tbl[7] = '{n:10, s:nom, lp:-1, idx:2, sc:9, ru:8, mg:1,
               err:1, gap:0, hold:0};
    tbl[8] = '{n:10, s:sv(5, 2, 9, 0, 1, 7, 3, 32'hFFFF_FFFF, 4, 6),
               lp:9, idx:7, sc:32'hFFFF_FFFF, ru:9,
               mg:32'hFFFF_FFF6, err:0, gap:0, hold:0};

    rst_n       = 1'b0;
    score_valid = 1'b0;
    score_data  = '0;
    score_last  = 1'b0;
    class_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      score_valid = 1'b1;
      score_data  = $urandom;
      score_last  = 1'($urandom);
      class_ready = 1'($urandom);
      #1;
      check_reset_state("reset");
    end
    @(negedge clk);
    score_valid = 1'b0;
    score_last  = 1'b0;
    class_ready = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset");

    for (int i = 0; i < 9; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Frame ending on the 10th beat without last: the next beat
    // must open a fresh frame at class 0.
    run_frame("nolast_again", tbl[7]);
    run_frame("after_nolast", tbl[0]);

    // Mid-frame reset discards the partial frame and the old result.
    send_beats(sv(100, 200, 300, 400, 500, 0, 0, 0, 0, 0), 5, -1, 0);
    chk("mid_valid_before", 32'(class_valid), 0);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after_mid_reset", tbl[0]);

    // Reset while a result is being presented.
    class_ready = 1'b0;
    send_beats(nom, 10, 9, 0);
    chk("pres_valid", 32'(class_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("pres_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int f = 0; f < 25; f++) begin
      logic [31:0] b, r;
      logic [3:0]  ix;
      logic        e;
      int          mode;
      for (int i = 0; i < 10; i++)
        v.s[i] = (f % 3 == 0) ? $urandom : 32'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        v.lp = $urandom_range(0, 8);
        v.n  = v.lp + 1;
      end else if (mode == 1) begin
        v.lp = -1;
        v.n  = 10;
      end else begin
        v.lp = 9;
        v.n  = 10;
      end
      model(v.s, v.n, v.lp, ix, b, r, e);
      v.idx  = ix;
      v.sc   = b;
      v.ru   = r;
      v.mg   = b - r;
      v.err  = e;
      v.gap  = (f % 2 == 0) ? 30 : 0;
      v.hold = $urandom_range(0, 3);
      run_frame($sformatf("rnd%0d", f), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
